// File: rtl/expr_eval_ctrl_pkg.sv
// Shared ASCII constants and FSM state encoding for the expression evaluator.
package expr_eval_ctrl_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OPND = 2'd1,
    S_OPTR = 2'd2,
    S_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/expr_char_decode.sv
// Combinational ASCII classifier: splits one character into token flags and a digit value.
// Zero latency; no flow control of its own.
module expr_char_decode
  import expr_eval_ctrl_pkg::*;
(
  input  logic [7:0] i_ch,
  output logic       o_is_digit,
  output logic       o_is_plus,
  output logic       o_is_mul,
  output logic       o_is_eq,
  output logic       o_is_bad,
  output logic [3:0] o_digit
);

  assign o_is_digit = (i_ch >= CH_0) && (i_ch <= CH_9);
  assign o_is_plus  = (i_ch == CH_PLUS);
  assign o_is_mul   = (i_ch == CH_MUL);
  assign o_is_eq    = (i_ch == CH_EQ);
  assign o_is_bad   = ~(o_is_digit | o_is_plus | o_is_mul | o_is_eq);
  // '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
  assign o_digit    = i_ch[3:0];

endmodule

// File: rtl/expr_eval_ctrl.sv
// Parses digit((+|*)digit)*'=' one char per valid cycle, evaluating with '*' over '+'.
// res_valid pulses the cycle after '=' is consumed; in_valid=0 simply holds all state.
module expr_eval_ctrl
  import expr_eval_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic         out,
  output logic         res_valid,
  output logic [W-1:0] result,
  output logic         err,
  output logic         ovf
);

  logic       w_is_digit, w_is_plus, w_is_mul, w_is_eq, w_is_bad;
  logic [3:0] w_digit;

  expr_char_decode u_dec (
    .i_ch       (in),
    .o_is_digit (w_is_digit),
    .o_is_plus  (w_is_plus),
    .o_is_mul   (w_is_mul),
    .o_is_eq    (w_is_eq),
    .o_is_bad   (w_is_bad),
    .o_digit    (w_digit)
  );

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_sum, r_term;
  logic           r_mul_pend, r_ovf_stk;
  logic           r_res_valid, r_err, r_ovf;
  logic [W-1:0]   r_result;
  logic [W+3:0]   w_prod;
  logic [W:0]     w_sum_add;

  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (in_valid) begin
      if (w_is_eq) begin
        w_state_nxt = S_IDLE;
      end else if (w_is_bad) begin
        w_state_nxt = S_ERR;
      end else begin
        case (r_state)
          S_IDLE, S_OPTR: w_state_nxt = w_is_digit ? S_OPND : S_ERR;
          S_OPND:         w_state_nxt = w_is_digit ? S_ERR : S_OPTR;
          default:        w_state_nxt = S_ERR;
        endcase
      end
    end
  end

  // Product kept 4 bits wider than the term so any spill past W bits is visible.
  assign w_prod    = r_mul_pend ? ({4'b0, r_term} * {{W{1'b0}}, w_digit})
                                : {{W{1'b0}}, w_digit};
  assign w_sum_add = {1'b0, r_sum} + {1'b0, r_term};

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sum       <= '0;
      r_term      <= '0;
      r_mul_pend  <= 1'b0;
      r_ovf_stk   <= 1'b0;
      r_res_valid <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (in_valid) begin
        if (w_is_eq) begin
          r_res_valid <= 1'b1;
          if (r_state == S_OPND) begin
            r_result <= w_sum_add[W-1:0];
            r_err    <= 1'b0;
            r_ovf    <= r_ovf_stk | w_sum_add[W];
          end else begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_ovf    <= 1'b0;
          end
          r_sum      <= '0;
          r_term     <= '0;
          r_mul_pend <= 1'b0;
          r_ovf_stk  <= 1'b0;
        end else if (w_is_digit) begin
          r_term <= w_prod[W-1:0];
          if (|w_prod[W+3:W]) r_ovf_stk <= 1'b1;
        end else if (w_is_mul) begin
          r_mul_pend <= 1'b1;
        end else if (w_is_plus) begin
          r_sum      <= w_sum_add[W-1:0];
          r_mul_pend <= 1'b0;
          if (w_sum_add[W]) r_ovf_stk <= 1'b1;
        end
      end
    end
  end

  assign out       = (r_state == S_OPND);
  assign res_valid = r_res_valid;
  assign result    = r_result;
  assign err       = r_err;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Directed bench for expr_eval_ctrl: inputs change on the falling edge, outputs are sampled there too.
module tb_expr_eval_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         in_valid;
  logic [7:0]   in_ch;
  logic         out_lvl;
  logic         res_valid;
  logic [W-1:0] result;
  logic         err;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  expr_eval_ctrl #(.W(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in        (in_ch),
    .out       (out_lvl),
    .res_valid (res_valid),
    .result    (result),
    .err       (err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] c);
    in_valid = v;
    in_ch    = c;
  endtask

  // now=1 drives the first character in the current cycle (back-to-back case).
  task automatic send_str(input string s, input bit now);
    for (int i = 0; i < s.len(); i++) begin
      if (!(now && i == 0)) @(negedge clk);
      drive(1'b1, s[i]);
    end
  endtask

  task automatic expect_res(input string tag, input int r, input bit e, input bit o);
    @(negedge clk);
    check_val({tag, ".res_valid"}, res_valid, 1);
    check_val({tag, ".result"},    result,    r);
    check_val({tag, ".err"},       err,       e);
    check_val({tag, ".ovf"},       ovf,       o);
    check_val({tag, ".out"},       out_lvl,   0);
    drive(1'b0, 8'h00);
  endtask

  initial begin
    clr = 1'b1;
    drive(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check_val("rst.out",       out_lvl,   0);
    check_val("rst.res_valid", res_valid, 0);
    check_val("rst.result",    result,    0);
    check_val("rst.err",       err,       0);
    check_val("rst.ovf",       ovf,       0);
    clr = 1'b0;

    // 3+5*9= with the out level tracked per character
    send_str("3", 0);
    @(negedge clk); check_val("a.out3", out_lvl, 1); drive(1'b1, "+");
    @(negedge clk); check_val("a.outp", out_lvl, 0); drive(1'b1, "5");
    @(negedge clk); check_val("a.out5", out_lvl, 1); drive(1'b1, "*");
    @(negedge clk); check_val("a.outm", out_lvl, 0); drive(1'b1, "9");
    @(negedge clk); check_val("a.out9", out_lvl, 1); drive(1'b1, "=");
    expect_res("a", 48, 0, 0);
    @(negedge clk);
    check_val("a.pulse_drop", res_valid, 0);
    check_val("a.hold",       result,    48);

    // back-to-back expressions
    send_str("9*9+9=", 0);
    expect_res("b1", 90, 0, 0);
    send_str("2=", 1);
    expect_res("b2", 2, 0, 0);

    send_str("3++5=", 0);  expect_res("dblop", 0, 1, 0);
    send_str("=", 0);      expect_res("eqonly", 0, 1, 0);
    send_str("37=", 0);    expect_res("multidig", 0, 1, 0);
    send_str("3+a=", 0);   expect_res("badch", 0, 1, 0);
    send_str("+3=", 0);    expect_res("leadop", 0, 1, 0);
    send_str("4*=", 0);    expect_res("trailop", 0, 1, 0);
    send_str("9*9*9=", 0); expect_res("ovfmul", 217, 0, 1);
    send_str("9*9+9*9*3=", 0); expect_res("ovfsum", 68, 0, 1);
    send_str("0*7+9*2=", 0);   expect_res("zero", 18, 0, 0);
    send_str("8*0*9=", 0);     expect_res("mulz", 0, 0, 0);

    // bubbles between characters hold state
    send_str("3", 0);
    @(negedge clk); drive(1'b0, "7");
    @(negedge clk); check_val("bub.out3", out_lvl, 1); drive(1'b1, "+");
    @(negedge clk); drive(1'b0, "=");
    @(negedge clk); check_val("bub.outp", out_lvl, 0);
    check_val("bub.novld", res_valid, 0); drive(1'b1, "5");
    @(negedge clk); drive(1'b0, "+");
    @(negedge clk); check_val("bub.out5", out_lvl, 1); drive(1'b1, "=");
    expect_res("bub", 8, 0, 0);

    // clr mid-expression discards the partial expression
    send_str("3+5", 0);
    @(negedge clk);
    check_val("clr.pre_vld", res_valid, 0);
    drive(1'b0, 8'h00);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("clr.vld",    res_valid, 0);
    check_val("clr.out",    out_lvl,   0);
    check_val("clr.result", result,    0);
    send_str("4=", 0);
    expect_res("clr.after", 4, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
